// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with load-use hazard detection, flush
//            squash, global memory-stall hold and a saturating counter of
//            load-use bubbles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ID_valid_i,
  input  logic              ID_RegWrite_i,
  input  logic              ID_MemtoReg_i,
  input  logic              ID_MemRead_i,
  input  logic              ID_MemWrite_i,
  input  logic [1:0]        ID_ALUOp_i,
  input  logic              ID_ALUSrc_i,
  input  logic [DATA_W-1:0] ID_rs1data_i,
  input  logic [DATA_W-1:0] ID_rs2data_i,
  input  logic [DATA_W-1:0] ID_imm_i,
  input  logic [9:0]        ID_funct_i,
  input  logic [4:0]        ID_rs1_i,
  input  logic [4:0]        ID_rs2_i,
  input  logic [4:0]        ID_rd_i,
  input  logic              Flush_i,
  input  logic              MemStall_i,
  output logic              EX_valid_o,
  output logic              EX_RegWrite_o,
  output logic              EX_MemtoReg_o,
  output logic              EX_MemRead_o,
  output logic              EX_MemWrite_o,
  output logic [1:0]        EX_ALUOp_o,
  output logic              EX_ALUSrc_o,
  output logic [DATA_W-1:0] EX_rs1data_o,
  output logic [DATA_W-1:0] EX_rs2data_o,
  output logic [DATA_W-1:0] EX_imm_o,
  output logic [9:0]        EX_funct_o,
  output logic [4:0]        EX_rs1_o,
  output logic [4:0]        EX_rs2_o,
  output logic [4:0]        EX_rd_o,
  output logic              Stall_o,
  output logic [CNT_W-1:0]  LoadUseCnt_o
);

  logic              valid_q,    valid_d;
  logic              regwrite_q, regwrite_d;
  logic              memtoreg_q, memtoreg_d;
  logic              memread_q,  memread_d;
  logic              memwrite_q, memwrite_d;
  logic [1:0]        aluop_q,    aluop_d;
  logic              alusrc_q,   alusrc_d;
  logic [DATA_W-1:0] rs1data_q,  rs1data_d;
  logic [DATA_W-1:0] rs2data_q,  rs2data_d;
  logic [DATA_W-1:0] imm_q,      imm_d;
  logic [9:0]        funct_q,    funct_d;
  logic [4:0]        rs1_q,      rs1_d;
  logic [4:0]        rs2_q,      rs2_d;
  logic [4:0]        rd_q,       rd_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;

  logic              hz_w;

  // Load in EX whose result a valid ID instruction needs: insert one bubble.
  always_comb begin
    hz_w = ID_valid_i & valid_q & memread_q & (rd_q != 5'd0) &
           ((rd_q == ID_rs1_i) | (rd_q == ID_rs2_i));
  end

  // A squashed instruction never holds the front end.
  assign Stall_o = hz_w & ~Flush_i;

  // Next-state selection: hold on memory stall, bubble on flush/hazard, else load.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    aluop_d    = aluop_q;
    alusrc_d   = alusrc_q;
    rs1data_d  = rs1data_q;
    rs2data_d  = rs2data_q;
    imm_d      = imm_q;
    funct_d    = funct_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    if (!MemStall_i) begin
      if (Flush_i || hz_w) begin
        // Bubble: zero indices so the forwarding unit never matches it;
        // datapath fields are don't-care and simply hold.
        valid_d    = 1'b0;
        regwrite_d = 1'b0;
        memtoreg_d = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        aluop_d    = 2'd0;
        alusrc_d   = 1'b0;
        rs1_d      = 5'd0;
        rs2_d      = 5'd0;
        rd_d       = 5'd0;
        if (!Flush_i && !(&cnt_q)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        // Side-effecting controls are gated when the ID slot is empty.
        valid_d    = ID_valid_i;
        regwrite_d = ID_RegWrite_i & ID_valid_i;
        memtoreg_d = ID_MemtoReg_i;
        memread_d  = ID_MemRead_i & ID_valid_i;
        memwrite_d = ID_MemWrite_i & ID_valid_i;
        aluop_d    = ID_ALUOp_i;
        alusrc_d   = ID_ALUSrc_i;
        rs1data_d  = ID_rs1data_i;
        rs2data_d  = ID_rs2data_i;
        imm_d      = ID_imm_i;
        funct_d    = ID_funct_i;
        rs1_d      = ID_rs1_i;
        rs2_d      = ID_rs2_i;
        rd_d       = ID_rd_i;
      end
    end
  end

  // Pipeline register and counter state, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      aluop_q    <= 2'd0;
      alusrc_q   <= 1'b0;
      rs1data_q  <= '0;
      rs2data_q  <= '0;
      imm_q      <= '0;
      funct_q    <= 10'd0;
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      rd_q       <= 5'd0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      aluop_q    <= aluop_d;
      alusrc_q   <= alusrc_d;
      rs1data_q  <= rs1data_d;
      rs2data_q  <= rs2data_d;
      imm_q      <= imm_d;
      funct_q    <= funct_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  assign EX_valid_o    = valid_q;
  assign EX_RegWrite_o = regwrite_q;
  assign EX_MemtoReg_o = memtoreg_q;
  assign EX_MemRead_o  = memread_q;
  assign EX_MemWrite_o = memwrite_q;
  assign EX_ALUOp_o    = aluop_q;
  assign EX_ALUSrc_o   = alusrc_q;
  assign EX_rs1data_o  = rs1data_q;
  assign EX_rs2data_o  = rs2data_q;
  assign EX_imm_o      = imm_q;
  assign EX_funct_o    = funct_q;
  assign EX_rs1_o      = rs1_q;
  assign EX_rs2_o      = rs2_q;
  assign EX_rd_o       = rd_q;
  assign LoadUseCnt_o  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Self-checking bench for id_ex_stage: directed scenarios with
//            literal expectations plus randomized traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        ID_valid_i = 0, ID_RegWrite_i = 0, ID_MemtoReg_i = 0;
  logic        ID_MemRead_i = 0, ID_MemWrite_i = 0, ID_ALUSrc_i = 0;
  logic [1:0]  ID_ALUOp_i = 0;
  logic [31:0] ID_rs1data_i = 0, ID_rs2data_i = 0, ID_imm_i = 0;
  logic [9:0]  ID_funct_i = 0;
  logic [4:0]  ID_rs1_i = 0, ID_rs2_i = 0, ID_rd_i = 0;
  logic        Flush_i = 0, MemStall_i = 0;

  logic        EX_valid_o, EX_RegWrite_o, EX_MemtoReg_o, EX_MemRead_o;
  logic        EX_MemWrite_o, EX_ALUSrc_o, Stall_o;
  logic [1:0]  EX_ALUOp_o;
  logic [31:0] EX_rs1data_o, EX_rs2data_o, EX_imm_o;
  logic [9:0]  EX_funct_o;
  logic [4:0]  EX_rs1_o, EX_rs2_o, EX_rd_o;
  logic [15:0] LoadUseCnt_o;

  // Second instance with a tiny counter to exercise saturation.
  logic        d2_valid, d2_rw, d2_m2r, d2_mr, d2_mw, d2_alusrc, d2_stall;
  logic [1:0]  d2_aluop;
  logic [31:0] d2_a, d2_b, d2_imm;
  logic [9:0]  d2_funct;
  logic [4:0]  d2_rs1, d2_rs2, d2_rd;
  logic [1:0]  d2_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b1;

  always #5 clk_i = ~clk_i;

  id_ex_stage #(.DATA_W(32), .CNT_W(16)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ID_valid_i(ID_valid_i), .ID_RegWrite_i(ID_RegWrite_i), .ID_MemtoReg_i(ID_MemtoReg_i),
    .ID_MemRead_i(ID_MemRead_i), .ID_MemWrite_i(ID_MemWrite_i), .ID_ALUOp_i(ID_ALUOp_i),
    .ID_ALUSrc_i(ID_ALUSrc_i), .ID_rs1data_i(ID_rs1data_i), .ID_rs2data_i(ID_rs2data_i),
    .ID_imm_i(ID_imm_i), .ID_funct_i(ID_funct_i), .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i),
    .ID_rd_i(ID_rd_i), .Flush_i(Flush_i), .MemStall_i(MemStall_i),
    .EX_valid_o(EX_valid_o), .EX_RegWrite_o(EX_RegWrite_o), .EX_MemtoReg_o(EX_MemtoReg_o),
    .EX_MemRead_o(EX_MemRead_o), .EX_MemWrite_o(EX_MemWrite_o), .EX_ALUOp_o(EX_ALUOp_o),
    .EX_ALUSrc_o(EX_ALUSrc_o), .EX_rs1data_o(EX_rs1data_o), .EX_rs2data_o(EX_rs2data_o),
    .EX_imm_o(EX_imm_o), .EX_funct_o(EX_funct_o), .EX_rs1_o(EX_rs1_o), .EX_rs2_o(EX_rs2_o),
    .EX_rd_o(EX_rd_o), .Stall_o(Stall_o), .LoadUseCnt_o(LoadUseCnt_o)
  );

  id_ex_stage #(.DATA_W(32), .CNT_W(2)) u_dut2 (
    .clk_i(clk_i), .rst_i(rst_i),
    .ID_valid_i(ID_valid_i), .ID_RegWrite_i(ID_RegWrite_i), .ID_MemtoReg_i(ID_MemtoReg_i),
    .ID_MemRead_i(ID_MemRead_i), .ID_MemWrite_i(ID_MemWrite_i), .ID_ALUOp_i(ID_ALUOp_i),
    .ID_ALUSrc_i(ID_ALUSrc_i), .ID_rs1data_i(ID_rs1data_i), .ID_rs2data_i(ID_rs2data_i),
    .ID_imm_i(ID_imm_i), .ID_funct_i(ID_funct_i), .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i),
    .ID_rd_i(ID_rd_i), .Flush_i(Flush_i), .MemStall_i(MemStall_i),
    .EX_valid_o(d2_valid), .EX_RegWrite_o(d2_rw), .EX_MemtoReg_o(d2_m2r),
    .EX_MemRead_o(d2_mr), .EX_MemWrite_o(d2_mw), .EX_ALUOp_o(d2_aluop),
    .EX_ALUSrc_o(d2_alusrc), .EX_rs1data_o(d2_a), .EX_rs2data_o(d2_b),
    .EX_imm_o(d2_imm), .EX_funct_o(d2_funct), .EX_rs1_o(d2_rs1), .EX_rs2_o(d2_rs2),
    .EX_rd_o(d2_rd), .Stall_o(d2_stall), .LoadUseCnt_o(d2_cnt)
  );

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic        valid, rw, m2r, mr, mw, alusrc;
    logic [1:0]  aluop;
    logic [31:0] a, b, imm;
    logic [9:0]  funct;
    logic [4:0]  rs1, rs2, rd;
    bit          dp_known;   // datapath fields defined (not after a bubble)
    int          cnt16, cnt2;
  } ex_model_t;

  ex_model_t m;

  function automatic ex_model_t empty_slot();
    ex_model_t e;
    e.valid = 0; e.rw = 0; e.m2r = 0; e.mr = 0; e.mw = 0; e.alusrc = 0;
    e.aluop = 0; e.a = 0; e.b = 0; e.imm = 0; e.funct = 0;
    e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.dp_known = 1; e.cnt16 = 0; e.cnt2 = 0;
    return e;
  endfunction

  // Does the valid ID instruction read the register a load in EX is fetching?
  function automatic bit needs_loaded_value();
    if (!(ID_valid_i && m.valid && m.mr)) return 0;
    if (m.rd == 0) return 0;
    return (m.rd == ID_rs1_i) || (m.rd == ID_rs2_i);
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m = empty_slot();
    end else if (!MemStall_i) begin
      if (Flush_i || needs_loaded_value()) begin
        if (!Flush_i) begin
          m.cnt16 = (m.cnt16 == 65535) ? 65535 : m.cnt16 + 1;
          m.cnt2  = (m.cnt2  == 3)     ? 3     : m.cnt2 + 1;
        end
        m.valid = 0; m.rw = 0; m.m2r = 0; m.mr = 0; m.mw = 0; m.alusrc = 0;
        m.aluop = 0; m.rs1 = 0; m.rs2 = 0; m.rd = 0; m.dp_known = 0;
      end else begin
        m.valid = ID_valid_i;
        m.rw = ID_valid_i ? ID_RegWrite_i : 1'b0;
        m.mr = ID_valid_i ? ID_MemRead_i  : 1'b0;
        m.mw = ID_valid_i ? ID_MemWrite_i : 1'b0;
        m.m2r = ID_MemtoReg_i; m.alusrc = ID_ALUSrc_i; m.aluop = ID_ALUOp_i;
        m.a = ID_rs1data_i; m.b = ID_rs2data_i; m.imm = ID_imm_i; m.funct = ID_funct_i;
        m.rs1 = ID_rs1_i; m.rs2 = ID_rs2_i; m.rd = ID_rd_i; m.dp_known = 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_i) begin
    if (cmp_en) begin
      chk("valid", EX_valid_o, m.valid);
      chk("regwrite", EX_RegWrite_o, m.rw);
      chk("memtoreg", EX_MemtoReg_o, m.m2r);
      chk("memread", EX_MemRead_o, m.mr);
      chk("memwrite", EX_MemWrite_o, m.mw);
      chk("alusrc", EX_ALUSrc_o, m.alusrc);
      chk("aluop", EX_ALUOp_o, m.aluop);
      chk("rs1", EX_rs1_o, m.rs1);
      chk("rs2", EX_rs2_o, m.rs2);
      chk("rd", EX_rd_o, m.rd);
      if (m.dp_known) begin
        chk("rs1data", EX_rs1data_o, m.a);
        chk("rs2data", EX_rs2data_o, m.b);
        chk("imm", EX_imm_o, m.imm);
        chk("funct", EX_funct_o, m.funct);
      end
      chk("stall", Stall_o, needs_loaded_value() && !Flush_i);
      chk("cnt16", LoadUseCnt_o, m.cnt16);
      chk("d2_valid", d2_valid, m.valid);
      chk("d2_rd", d2_rd, m.rd);
      chk("d2_stall", d2_stall, needs_loaded_value() && !Flush_i);
      chk("d2_cnt", d2_cnt, m.cnt2);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_id(input bit v, input bit rw, input bit m2r, input bit mr, input bit mw,
                        input logic [1:0] op, input bit src,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    ID_valid_i = v; ID_RegWrite_i = rw; ID_MemtoReg_i = m2r; ID_MemRead_i = mr;
    ID_MemWrite_i = mw; ID_ALUOp_i = op; ID_ALUSrc_i = src;
    ID_rs1_i = rs1; ID_rs2_i = rs2; ID_rd_i = rd;
    ID_rs1data_i = $urandom; ID_rs2data_i = $urandom; ID_imm_i = $urandom;
    ID_funct_i = 10'($urandom);
  endtask

  task automatic set_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    set_id(1, 1, 0, 0, 0, 2'd2, 0, rs1, rs2, rd);
  endtask

  task automatic set_lw(input logic [4:0] rd, input logic [4:0] rs1);
    set_id(1, 1, 1, 1, 0, 2'd0, 1, rs1, 5'd0, rd);
  endtask

  initial begin
    // Reset state.
    repeat (2) step();
    chk("lit_rst_valid", EX_valid_o, 0);
    chk("lit_rst_cnt", LoadUseCnt_o, 0);
    chk("lit_rst_stall", Stall_o, 0);
    rst_i = 1'b1;

    // add x3,x1,x2 passes straight through.
    set_add(5'd3, 5'd1, 5'd2);
    step();
    chk("lit_add_rd", EX_rd_o, 3);
    chk("lit_add_rw", EX_RegWrite_o, 1);
    chk("lit_add_rs1", EX_rs1_o, 1);
    chk("lit_add_rs2", EX_rs2_o, 2);
    set_lw(5'd5, 5'd1);
    #1 chk("lit_add_stall", Stall_o, 0);

    // lw x5 followed by add x6,x5,x7: one bubble.
    step();
    set_add(5'd6, 5'd5, 5'd7);
    #1 chk("lit_lu_stall", Stall_o, 1);
    step();
    chk("lit_bub_valid", EX_valid_o, 0);
    chk("lit_bub_rd", EX_rd_o, 0);
    chk("lit_bub_cnt", LoadUseCnt_o, 1);
    chk("lit_bub_stall", Stall_o, 0);
    step();
    chk("lit_iss_rs1", EX_rs1_o, 5);
    chk("lit_iss_valid", EX_valid_o, 1);
    chk("lit_iss_stall", Stall_o, 0);

    // Load to x0 never stalls.
    set_lw(5'd0, 5'd2);
    step();
    set_add(5'd8, 5'd0, 5'd0);
    #1 chk("lit_x0_stall", Stall_o, 0);
    step();
    chk("lit_x0_rd", EX_rd_o, 8);
    chk("lit_x0_cnt", LoadUseCnt_o, 1);

    // Hazard with flush: no stall, bubble, counter unchanged.
    set_lw(5'd9, 5'd1);
    step();
    set_add(5'd10, 5'd9, 5'd9);
    Flush_i = 1'b1;
    #1 chk("lit_fl_stall", Stall_o, 0);
    step();
    Flush_i = 1'b0;
    chk("lit_fl_valid", EX_valid_o, 0);
    chk("lit_fl_cnt", LoadUseCnt_o, 1);

    // Memory stall held over a load-use hazard (rd matches both sources).
    set_lw(5'd11, 5'd1);
    step();
    set_add(5'd12, 5'd11, 5'd11);
    MemStall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lit_ms_rd", EX_rd_o, 11);
      chk("lit_ms_mr", EX_MemRead_o, 1);
      chk("lit_ms_cnt", LoadUseCnt_o, 1);
      chk("lit_ms_stall", Stall_o, 1);
    end
    MemStall_i = 1'b0;
    step();
    chk("lit_ms_bub", EX_valid_o, 0);
    chk("lit_ms_cnt2", LoadUseCnt_o, 2);
    step();
    chk("lit_ms_iss", EX_rd_o, 12);
    chk("lit_ms_cnt3", LoadUseCnt_o, 2);

    // Fresh reset, then five load-use bubbles on the 2-bit counter.
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_lw(5'd4, 5'd1);
      step();
      set_add(5'd7, 5'd2, 5'd4);
      step();
      chk("lit_sat_cnt2", d2_cnt, (i < 3) ? i + 1 : 3);
      chk("lit_sat_cnt16", LoadUseCnt_o, i + 1);
      step();
    end
    // Asynchronous reset while a hazard is pending.
    set_lw(5'd4, 5'd1);
    step();
    set_add(5'd7, 5'd4, 5'd2);
    #1 chk("lit_pre_rst_stall", Stall_o, 1);
    #1 rst_i = 1'b0;
    #1;
    chk("lit_arst_cnt", LoadUseCnt_o, 0);
    chk("lit_arst_cnt2", d2_cnt, 0);
    chk("lit_arst_rd", EX_rd_o, 0);
    chk("lit_arst_mr", EX_MemRead_o, 0);
    chk("lit_arst_stall", Stall_o, 0);
    step();
    rst_i = 1'b1;
    step();
    chk("lit_post_rst_valid", EX_valid_o, 1);
    chk("lit_post_rst_rd", EX_rd_o, 7);

    // Randomized traffic, small register range to provoke hazards.
    for (int n = 0; n < 4000; n++) begin
      set_id($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)));
      Flush_i = ($urandom_range(0, 9) == 0);
      MemStall_i = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_i = 1'b0;
        step();
        rst_i = 1'b1;
      end else begin
        step();
      end
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
